// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one word read at a time, and buffers returned
// instructions in a 2-entry FIFO feeding the IF/ID register. Redirects flush and refetch.
module if_fetch_stage #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h4000_0060
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IF_stall_i,
  input  logic             IF_redirect_i,
  input  logic [WIDTH-1:0] IF_redirect_pc_i,
  input  logic             imem_resp_i,
  input  logic [WIDTH-1:0] imem_rdata_i,
  output logic             imem_read_o,
  output logic [WIDTH-1:0] imem_address_o,
  output logic [WIDTH-1:0] IF_instr_o,
  output logic [WIDTH-1:0] IF_pc_out_o,
  output logic             IF_valid_o
);

  typedef enum logic [1:0] {StFetch, StIdle, StDrain} state_e;

  state_e           state_q, state_d;
  logic [1:0]       count_q, count_d;
  logic             rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [WIDTH-1:0] instr_q [2];
  logic [WIDTH-1:0] pc_ent_q [2];
  logic [WIDTH-1:0] pc_q, pc_d, req_addr_q, req_addr_d;
  logic [WIDTH-1:0] target, req_addr_inc;
  logic             enq, deq;

  assign target       = IF_redirect_pc_i & ~WIDTH'(3);
  assign req_addr_inc = req_addr_q + WIDTH'(4);

  assign IF_valid_o     = (count_q != 2'd0);
  assign deq            = IF_valid_o & ~IF_stall_i & ~IF_redirect_i;
  assign enq            = (state_q == StFetch) & imem_resp_i & ~IF_redirect_i;
  // Gated by rst so the request drops the instant reset asserts.
  assign imem_read_o    = (state_q != StIdle) & ~rst;
  assign imem_address_o = req_addr_q;
  assign IF_instr_o     = IF_valid_o ? instr_q[rd_ptr_q] : '0;
  assign IF_pc_out_o    = IF_valid_o ? pc_ent_q[rd_ptr_q] : '0;

  always_comb begin
    count_d  = count_q + 2'(enq) - 2'(deq);
    rd_ptr_d = rd_ptr_q ^ deq;
    wr_ptr_d = wr_ptr_q ^ enq;
    if (IF_redirect_i) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    unique case (state_q)
      StFetch: begin
        if (imem_resp_i) begin
          if (IF_redirect_i) begin
            req_addr_d = target;
            pc_d       = target;
          end else begin
            pc_d = req_addr_inc;
            if (count_d < 2'd2) req_addr_d = req_addr_inc;
            else                state_d    = StIdle;
          end
        end else if (IF_redirect_i) begin
          // The outstanding read cannot be cancelled; wait it out in drain.
          pc_d    = target;
          state_d = StDrain;
        end
      end
      StIdle: begin
        if (IF_redirect_i) begin
          req_addr_d = target;
          pc_d       = target;
          state_d    = StFetch;
        end else if (count_d < 2'd2) begin
          req_addr_d = pc_q;
          state_d    = StFetch;
        end
      end
      StDrain: begin
        if (imem_resp_i) begin
          req_addr_d = IF_redirect_i ? target : pc_q;
          pc_d       = IF_redirect_i ? target : pc_q;
          state_d    = StFetch;
        end else if (IF_redirect_i) begin
          pc_d = target;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StFetch;
      count_q     <= 2'd0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      instr_q[0]  <= '0;
      instr_q[1]  <= '0;
      pc_ent_q[0] <= '0;
      pc_ent_q[1] <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      if (enq) begin
        instr_q[wr_ptr_q]  <= imem_rdata_i;
        pc_ent_q[wr_ptr_q] <= req_addr_q;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: a latency-configurable memory model checks served
// addresses, and a monitor checks every instruction the decode side consumes.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        IF_stall_i, IF_redirect_i;
  logic [31:0] IF_redirect_pc_i;
  logic        imem_resp_i;
  logic [31:0] imem_rdata_i;
  logic        imem_read_o;
  logic [31:0] imem_address_o, IF_instr_o, IF_pc_out_o;
  logic        IF_valid_o;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_out_q[$];
  int          mem_lat = 1;
  int          mem_grant = 0;
  int          mem_used = 0;

  if_fetch_stage dut (
    .clk              (clk),
    .rst              (rst),
    .IF_stall_i       (IF_stall_i),
    .IF_redirect_i    (IF_redirect_i),
    .IF_redirect_pc_i (IF_redirect_pc_i),
    .imem_resp_i      (imem_resp_i),
    .imem_rdata_i     (imem_rdata_i),
    .imem_read_o      (imem_read_o),
    .imem_address_o   (imem_address_o),
    .IF_instr_o       (IF_instr_o),
    .IF_pc_out_o      (IF_pc_out_o),
    .IF_valid_o       (IF_valid_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push_seq(input logic [31:0] start, input int n, input bit to_out);
    for (int i = 0; i < n; i++) begin
      exp_addr_q.push_back(start + 32'(4 * i));
      if (to_out) exp_out_q.push_back(start + 32'(4 * i));
    end
  endtask

  // Memory model: drives resp/rdata at posedge+1, serves at most mem_grant requests.
  initial begin : memory
    bit          busy = 0;
    int          cnt = 0;
    logic [31:0] req_a = '0;
    imem_resp_i  = 1'b0;
    imem_rdata_i = '0;
    forever begin
      @(posedge clk);
      #1;
      imem_resp_i = 1'b0;
      if (rst) begin
        busy = 0;
      end else begin
        if (!busy && imem_read_o && mem_used < mem_grant) begin
          busy  = 1;
          cnt   = mem_lat;
          req_a = imem_address_o;
          mem_used++;
        end
        if (busy) begin
          check("addr_hold", imem_address_o, req_a);
          cnt--;
          if (cnt == 0) begin
            busy         = 0;
            imem_resp_i  = 1'b1;
            imem_rdata_i = mem_data(req_a);
            if (exp_addr_q.size() == 0) check("addr_extra", req_a, 32'hxxxx_xxxx);
            else check("served_addr", req_a, exp_addr_q.pop_front());
          end
        end
      end
    end
  end

  // Monitor: every consumed head entry must be the next expected PC with its data.
  always @(negedge clk) begin
    if (!rst && IF_valid_o && !IF_stall_i && !IF_redirect_i) begin
      if (exp_out_q.size() == 0) begin
        check("out_extra", IF_pc_out_o, 32'hxxxx_xxxx);
      end else begin
        logic [31:0] e;
        e = exp_out_q.pop_front();
        check("out_pc", IF_pc_out_o, e);
        check("out_instr", IF_instr_o, mem_data(e));
      end
    end
  end

  initial begin : stim
    bit found;
    rst = 1'b1;
    IF_stall_i = 1'b0;
    IF_redirect_i = 1'b0;
    IF_redirect_pc_i = '0;

    // Reset state, then straight-line fetch with 1-cycle memory.
    step(3);
    check("rst_read", 32'(imem_read_o), 32'd0);
    check("rst_valid", 32'(IF_valid_o), 32'd0);
    check("rst_instr", IF_instr_o, 32'd0);
    check("rst_pc", IF_pc_out_o, 32'd0);
    mem_lat = 1;
    mem_grant += 6;
    push_seq(32'h4000_0060, 6, 1);
    rst = 1'b0;
    #1;
    check("first_read", 32'(imem_read_o), 32'd1);
    check("first_addr", imem_address_o, 32'h4000_0060);
    step(20);
    check("t1_wait_addr", imem_address_o, 32'h4000_0078);

    // Stall fills the FIFO and parks the fetcher in idle.
    IF_stall_i = 1'b1;
    mem_grant += 6;
    push_seq(32'h4000_0078, 6, 1);
    step(6);
    check("stall_read", 32'(imem_read_o), 32'd0);
    check("stall_valid", 32'(IF_valid_o), 32'd1);
    check("stall_head_pc", IF_pc_out_o, 32'h4000_0078);
    check("stall_head_instr", IF_instr_o, mem_data(32'h4000_0078));
    IF_stall_i = 1'b0;
    step(20);
    check("t2_wait_addr", imem_address_o, 32'h4000_0090);

    // Redirect while a 3-cycle fetch of 0x70 is outstanding.
    rst = 1'b1;
    step(2);
    mem_lat = 3;
    mem_grant += 7;
    push_seq(32'h4000_0060, 3, 1);
    exp_addr_q.push_back(32'h4000_006C);
    exp_addr_q.push_back(32'h4000_0070);
    push_seq(32'h4000_0100, 2, 1);
    rst = 1'b0;
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      step();
      if (imem_read_o && imem_address_o == 32'h4000_0070) found = 1;
    end
    check("wait_addr70", 32'(found), 32'd1);
    IF_redirect_i = 1'b1;
    IF_redirect_pc_i = 32'h4000_0100;
    step();
    IF_redirect_i = 1'b0;
    check("drain_valid", 32'(IF_valid_o), 32'd0);
    check("drain_read", 32'(imem_read_o), 32'd1);
    check("drain_addr", imem_address_o, 32'h4000_0070);
    step(40);
    check("t3_wait_addr", imem_address_o, 32'h4000_0108);

    // Redirect coincident with resp, to an unaligned target.
    mem_lat = 1;
    mem_grant += 2;
    exp_addr_q.push_back(32'h4000_0108);
    push_seq(32'h4000_0200, 1, 1);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (imem_resp_i) found = 1;
    end
    check("wait_resp", 32'(found), 32'd1);
    IF_redirect_i = 1'b1;
    IF_redirect_pc_i = 32'h4000_0203;
    step();
    IF_redirect_i = 1'b0;
    check("align_addr", imem_address_o, 32'h4000_0200);
    step(10);
    check("t4_wait_addr", imem_address_o, 32'h4000_0204);

    // Redirect to the top word: sequential fetch wraps to zero.
    IF_redirect_i = 1'b1;
    IF_redirect_pc_i = 32'hFFFF_FFFC;
    mem_grant += 3;
    exp_addr_q.push_back(32'h4000_0204);
    push_seq(32'hFFFF_FFFC, 2, 1);
    step();
    IF_redirect_i = 1'b0;
    step(10);
    check("wrap_wait_addr", imem_address_o, 32'h0000_0004);

    // Reset asserted mid-request with a valid entry held by stall.
    IF_stall_i = 1'b1;
    mem_grant += 1;
    exp_addr_q.push_back(32'h0000_0004);
    step(5);
    check("pre_rst_valid", 32'(IF_valid_o), 32'd1);
    check("pre_rst_pc", IF_pc_out_o, 32'h0000_0004);
    check("pre_rst_read", 32'(imem_read_o), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_read", 32'(imem_read_o), 32'd0);
    check("async_rst_valid", 32'(IF_valid_o), 32'd0);
    check("async_rst_pc", IF_pc_out_o, 32'd0);
    step(2);
    IF_stall_i = 1'b0;
    mem_lat = 2;
    mem_grant += 2;
    push_seq(32'h4000_0060, 2, 1);
    rst = 1'b0;
    #1;
    check("rerst_read", 32'(imem_read_o), 32'd1);
    check("rerst_addr", imem_address_o, 32'h4000_0060);
    step(20);
    check("t7_wait_addr", imem_address_o, 32'h4000_0068);

    check("addr_left", 32'(exp_addr_q.size()), 32'd0);
    check("out_left", 32'(exp_out_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
